// File: rtl/rst_seq_ctrl_if.sv
// Port bundle for rst_seq_ctrl: software request and per-stage acks in,
// staged resets and status out.
interface rst_seq_ctrl_if #(
  parameter int unsigned N_STAGES = 4
);
  logic                sw_rst_req_i;
  logic [N_STAGES-1:0] ack_i;
  logic [N_STAGES-1:0] rst_o;
  logic                busy_o;
  logic                done_o;
  logic                err_o;

  modport master (
    input  sw_rst_req_i, ack_i,
    output rst_o, busy_o, done_o, err_o
  );

  modport slave (
    output sw_rst_req_i, ack_i,
    input  rst_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: async assert, synchronized deassert, staged ordered release with acks.
// Optional ack timeout with sticky err_o is enabled by defining RST_SEQ_ACK_TIMEOUT_EN.
module rst_seq_ctrl #(
  parameter int unsigned N_STAGES    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRETCH     = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_i,
  rst_seq_ctrl_if.master bus
);

  localparam int unsigned IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int unsigned CNT_W = $clog2(STRETCH + 1);
  // The state register acts as the last synchronizer flop, so the chain holds one fewer.
  localparam int unsigned SQ_W  = SYNC_STAGES - 1;

  if (N_STAGES < 1 || SYNC_STAGES < 2 || STRETCH < 1 || ACK_TIMEOUT < 1) begin : g_param_check
    $error("rst_seq_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_SYNC,
    S_STRETCH,
    S_WAIT_ACK,
    S_RUN,
    S_SW_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [SQ_W-1:0]     sync_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_STAGES-1:0] rst_q, rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ack_ok_c;
  logic                last_c;

`ifdef RST_SEQ_ACK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            err_q, err_d;
  logic            to_hit_c;

  assign to_hit_c = (tcnt_q == TO_W'(ACK_TIMEOUT - 1));
`endif

  // Deassertion synchronizer, asynchronously set by rst_i
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_q << 1;
    end
  end

  assign last_c = (idx_q == IDX_W'(N_STAGES - 1));

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rst_d    = rst_q;
    ack_ok_c = 1'b0;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    err_d    = err_q;
`endif

    case (state_q)
      S_SYNC: begin
        if (!sync_q[SQ_W-1]) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
        end
      end

      S_STRETCH: begin
        if (cnt_q == CNT_W'(STRETCH)) begin
          rst_d[idx_q] = 1'b0;
          state_d      = S_WAIT_ACK;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
          tcnt_d       = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_ACK: begin
`ifdef RST_SEQ_ACK_TIMEOUT_EN
        // A timeout is treated exactly like an ack, but flags err_o
        ack_ok_c = bus.ack_i[idx_q] | to_hit_c;
        if (!bus.ack_i[idx_q]) begin
          if (to_hit_c) begin
            err_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TO_W'(1);
          end
        end
`else
        ack_ok_c = bus.ack_i[idx_q];
`endif
        if (ack_ok_c) begin
          if (last_c) begin
            state_d = S_RUN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = '0;
            state_d = S_STRETCH;
          end
        end
      end

      S_RUN: begin
        if (bus.sw_rst_req_i) begin
          state_d = S_SW_HOLD;
          rst_d   = '1;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end

      S_SW_HOLD: begin
        if (cnt_q == CNT_W'(STRETCH - 1)) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_SYNC;
        rst_d   = '1;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_RUN);
    done_d = (state_d == S_RUN);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_SYNC;
      idx_q   <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef RST_SEQ_ACK_TIMEOUT_EN
  // Ack timeout counter and sticky error flag
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.rst_o  = rst_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: power-on release timing, ack stall,
// software re-sequence, reset glitches in RUN and mid-sequence.
module tb_rst_seq_ctrl;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;
  int   e = 0;
  int   r = 0;

  rst_seq_ctrl_if #(.N_STAGES(N)) bus ();

  rst_seq_ctrl #(
    .N_STAGES   (N),
    .SYNC_STAGES(2),
    .STRETCH    (4),
    .ACK_TIMEOUT(64)
  ) dut (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

`ifdef RST_SEQ_ACK_TIMEOUT_EN
  rst_seq_ctrl_if #(.N_STAGES(N)) bus_to ();

  rst_seq_ctrl #(
    .N_STAGES   (N),
    .SYNC_STAGES(2),
    .STRETCH    (4),
    .ACK_TIMEOUT(8)
  ) dut_to (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (bus_to)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance to just after rising edge k, counted from the last rebase
  task automatic to_edge(input int k);
    while (e < k) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i            = 1'b0;
    bus.sw_rst_req_i = 1'b0;
    bus.ack_i        = 4'hF;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    bus_to.sw_rst_req_i = 1'b0;
    bus_to.ack_i        = 4'hE;
`endif
    #1 rst_i = 1'b1;
    #1;
    chk("reset_rst_o", 32'(bus.rst_o), 32'hF);
    chk("reset_busy", 32'(bus.busy_o), 32'd1);
    chk("reset_done", 32'(bus.done_o), 32'd0);
    chk("reset_err", 32'(bus.err_o), 32'd0);

    // Power-on: rst_i released before edge 1
    @(posedge clk);
    @(posedge clk);
    #2 rst_i = 1'b0;
    e = 0;
    to_edge(6);
    chk("po_e6_rst_o", 32'(bus.rst_o), 32'hF);
    to_edge(7);
    chk("po_e7_rst_o", 32'(bus.rst_o), 32'hE);
    chk("po_e7_busy", 32'(bus.busy_o), 32'd1);
    to_edge(12);
    chk("po_e12_rst_o", 32'(bus.rst_o), 32'hE);
    to_edge(13);
    chk("po_e13_rst_o", 32'(bus.rst_o), 32'hC);
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    to_edge(14);
    chk("to_e14_err", 32'(bus_to.err_o), 32'd0);
    chk("to_e14_rst_o", 32'(bus_to.rst_o), 32'hE);
    to_edge(15);
    chk("to_e15_err", 32'(bus_to.err_o), 32'd1);
`endif
    to_edge(18);
    chk("po_e18_rst_o", 32'(bus.rst_o), 32'hC);
    to_edge(19);
    chk("po_e19_rst_o", 32'(bus.rst_o), 32'h8);
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    to_edge(20);
    chk("to_e20_rst_o", 32'(bus_to.rst_o), 32'hC);
`endif
    to_edge(24);
    chk("po_e24_rst_o", 32'(bus.rst_o), 32'h8);
    to_edge(25);
    chk("po_e25_rst_o", 32'(bus.rst_o), 32'h0);
    chk("po_e25_done", 32'(bus.done_o), 32'd0);
    to_edge(26);
    chk("po_e26_done", 32'(bus.done_o), 32'd1);
    chk("po_e26_busy", 32'(bus.busy_o), 32'd0);

    // Acks dropping after release must not re-reset anything
    bus.ack_i = 4'h0;
    to_edge(30);
    chk("ackdrop_rst_o", 32'(bus.rst_o), 32'h0);
    chk("ackdrop_done", 32'(bus.done_o), 32'd1);
    bus.ack_i = 4'hF;

    // Software reset sampled on edge r; ack_i[1] stalls the second stage
    bus.sw_rst_req_i = 1'b1;
    r = 31;
    to_edge(r);
    chk("sw_rst_o", 32'(bus.rst_o), 32'hF);
    chk("sw_busy", 32'(bus.busy_o), 32'd1);
    chk("sw_done", 32'(bus.done_o), 32'd0);
    bus.sw_rst_req_i = 1'b0;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    to_edge(33);
    chk("to_run_done", 32'(bus_to.done_o), 32'd1);
    chk("to_run_err", 32'(bus_to.err_o), 32'd1);
`endif
    to_edge(r + 2);
    bus.sw_rst_req_i = 1'b1;
    bus.ack_i        = 4'hD;
    to_edge(r + 8);
    chk("sw_hold_rst_o", 32'(bus.rst_o), 32'hF);
    to_edge(r + 9);
    chk("sw_rel0_rst_o", 32'(bus.rst_o), 32'hE);
    to_edge(r + 10);
    chk("sw_ignored_rst_o", 32'(bus.rst_o), 32'hE);
    bus.sw_rst_req_i = 1'b0;
    to_edge(r + 15);
    chk("sw_rel1_rst_o", 32'(bus.rst_o), 32'hC);
    to_edge(r + 35);
    chk("stall_rst_o", 32'(bus.rst_o), 32'hC);
    chk("stall_err", 32'(bus.err_o), 32'd0);
    chk("stall_busy", 32'(bus.busy_o), 32'd1);
    bus.ack_i = 4'hF;
    to_edge(r + 40);
    chk("stall_e40_rst_o", 32'(bus.rst_o), 32'hC);
    to_edge(r + 41);
    chk("stall_rel2_rst_o", 32'(bus.rst_o), 32'h8);
    to_edge(r + 47);
    chk("sw_rel3_rst_o", 32'(bus.rst_o), 32'h0);
    to_edge(r + 48);
    chk("sw_run_done", 32'(bus.done_o), 32'd1);
    chk("sw_run_err", 32'(bus.err_o), 32'd0);

    // Short rst_i glitch in RUN
    rst_i = 1'b1;
    #1;
    chk("glitch_rst_o", 32'(bus.rst_o), 32'hF);
    chk("glitch_done", 32'(bus.done_o), 32'd0);
    chk("glitch_busy", 32'(bus.busy_o), 32'd1);
    rst_i = 1'b0;
    e = 0;
    to_edge(6);
    chk("gl_e6_rst_o", 32'(bus.rst_o), 32'hF);
    to_edge(7);
    chk("gl_e7_rst_o", 32'(bus.rst_o), 32'hE);
    to_edge(13);
    chk("gl_e13_rst_o", 32'(bus.rst_o), 32'hC);
    to_edge(16);
    chk("gl_e16_done", 32'(bus.done_o), 32'd0);

    // Mid-sequence pulse while the third stage is pending
    rst_i = 1'b1;
    #1;
    chk("mid_rst_o", 32'(bus.rst_o), 32'hF);
    chk("mid_done", 32'(bus.done_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("mid_after_rst_o", 32'(bus.rst_o), 32'hF);
    e = 0;
    to_edge(7);
    chk("mid_e7_rst_o", 32'(bus.rst_o), 32'hE);
    to_edge(13);
    chk("mid_e13_rst_o", 32'(bus.rst_o), 32'hC);
    to_edge(19);
    chk("mid_e19_rst_o", 32'(bus.rst_o), 32'h8);
    to_edge(25);
    chk("mid_e25_rst_o", 32'(bus.rst_o), 32'h0);
    chk("mid_e25_done", 32'(bus.done_o), 32'd0);
    to_edge(26);
    chk("mid_e26_done", 32'(bus.done_o), 32'd1);
    chk("mid_e26_busy", 32'(bus.busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
